esi_cycle_count_responder: RTL and testbench
============================================

Name: esi_cycle_count_responder

Overview:
- Hardware-side responder that services cycle-count and clock-frequency queries arriving from the host over an ESI valid/ready request channel.
- Owns a free-running 64-bit cycle counter and returns snapshots of it on an ESI valid/ready response channel.
- Also returns the configured core clock frequency and a "lap" delta (cycles elapsed since the previous lap query).
- Instantiated once per design, next to the host-facing ESI service ports; usable in both cosim and on hardware.

Parameters:
- CORE_CLOCK_FREQUENCY_HZ, 100_000_000, core clock frequency in Hz, returned by the READ_FREQ op (64-bit unsigned).

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  request channel valid.
- req_ready  out  1  request channel ready.
- req_op  in  2  opcode: 0 READ_COUNT, 1 READ_FREQ, 2 READ_LAP, 3 reserved.
- resp_valid  out  1  response channel valid.
- resp_ready  in  1  response channel ready.
- resp_data  out  64  response payload.
- resp_op  out  2  echo of the opcode of the request being answered.
- resp_err  out  1  1 when the answered request used reserved opcode 3.
- cycle_count  out  64  live counter value, for local debug and observation.

Behaviour:
- Reset (rst=0, asynchronous):
  - Immediately sets cycle_count=0, lap register=0, resp_valid=0, resp_data=0, resp_op=0, resp_err=0; FSM goes to IDLE.
  - A pending response is dropped, and no request is accepted while rst=0 (req_ready=0).
  - After release, the first posedge increments cycle_count to 1.
- Counter:
  - Increments by 1 every posedge while out of reset.
  - Wraps from 2^64-1 to 0 with no flag.
- Handshake:
  - A transfer occurs on a posedge where valid and ready are both 1.
  - req_ready = rst && (!resp_valid || resp_ready). This combinational path from resp_ready is intended and gives one-deep, back-to-back throughput.
- FSM states:
  - IDLE (resp_valid=0): a request accepted → RESP; otherwise stay in IDLE.
  - RESP (resp_valid=1): resp_ready=1 with no new request → IDLE. resp_ready=1 with a new request accepted in the same cycle → stay in RESP and load the new response. resp_ready=0 → stay in RESP.
- Latency: the response is valid on the cycle after acceptance (1-cycle latency).
- Response hold: resp_data, resp_op and resp_err are registered and stay stable while resp_valid=1 and resp_ready=0.
- Snapshot timing: the snapshot is the cycle_count register value in the accept cycle, i.e. before that edge's increment.
- Opcodes:
  - READ_COUNT: resp_data = snapshot.
  - READ_FREQ: resp_data = CORE_CLOCK_FREQUENCY_HZ.
  - READ_LAP: resp_data = (snapshot − lap) mod 2^64; lap ← snapshot on the accept edge. The first lap after reset therefore returns the snapshot itself.
  - Op 3: resp_data = 64'hFFFF_FFFF_FFFF_FFFF, resp_err=1. No state changes other than the response.
- Simultaneous events: lap update and response load take effect on the same edge as the counter increment; neither blocks the counter.
- Invariant: requests are never lost or duplicated; exactly one response per accepted request, in acceptance order.

Test Plan:
- Reset, then hold rst=1 for 10 cycles with req_valid=0 → cycle_count=10, resp_valid=0, req_ready=1.
- In IDLE, present READ_COUNT when cycle_count=5 → next cycle resp_valid=1, resp_data=5, resp_op=0, resp_err=0.
- READ_FREQ with the default parameter and resp_ready=0 for 4 cycles → resp_data=100_000_000 held stable with resp_valid=1 and req_ready=0 throughout; one transfer when resp_ready rises.
- READ_LAP accepted at count 7, then again at count 20 → responses 7 then 13. Force the counter to 2^64-2, then READ_LAP with lap=2^64-4 → response 2. Let the counter wrap from 2^64-1 → cycle_count=0.
- Back-to-back: req_valid=1 and resp_ready=1 continuously with ops 0,1,3 → one response per cycle in order; op 3 returns all-ones with resp_err=1.
- Assert rst=0 mid-cycle while resp_valid=1 → resp_valid, cycle_count and lap clear immediately, without waiting for a clock edge; after release, READ_LAP returns the current count.

Source files
------------

// File: rtl/esi_cycle_count_responder.sv
// Cycle-count responder: answers host queries for the free-running 64-bit
// cycle counter, the core clock frequency and lap deltas over an ESI
// valid/ready request/response pair with a one-deep response register.
module esi_cycle_count_responder #(
    parameter logic [63:0] CORE_CLOCK_FREQUENCY_HZ = 64'd100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic [1:0]  resp_op,
    output logic        resp_err,
    output logic [63:0] cycle_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic [1:0] OP_READ_COUNT = 2'd0;
    localparam logic [1:0] OP_READ_FREQ  = 2'd1;
    localparam logic [1:0] OP_READ_LAP   = 2'd2;

    state_t      state_q;
    state_t      state_d;
    logic [63:0] count_q;
    logic [63:0] lap_q;
    logic [63:0] load_data;
    logic        load_err;
    logic        req_fire;

    assign resp_valid  = (state_q == RESP);
    assign req_ready   = rst && (!resp_valid || resp_ready);
    assign req_fire    = req_valid && req_ready;
    assign cycle_count = count_q;

    // Next-state: an accepted request always leaves a response pending;
    // a drained response with nothing new behind it returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready && !req_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response payload selected by opcode from the pre-increment counter value.
    always_comb begin
        load_data = '0;
        load_err  = 1'b0;
        case (req_op)
            OP_READ_COUNT: load_data = count_q;
            OP_READ_FREQ:  load_data = CORE_CLOCK_FREQUENCY_HZ;
            OP_READ_LAP:   load_data = count_q - lap_q;
            default: begin
                load_data = '1;
                load_err  = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Free-running cycle counter; wraps silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 64'd1;
        end
    end

    // Lap reference captures the snapshot of every accepted lap query.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_q <= '0;
        end else if (req_fire && (req_op == OP_READ_LAP)) begin
            lap_q <= count_q;
        end
    end

    // Response register loads on acceptance and holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_data <= '0;
            resp_op   <= '0;
            resp_err  <= 1'b0;
        end else if (req_fire) begin
            resp_data <= load_data;
            resp_op   <= req_op;
            resp_err  <= load_err;
        end
    end

endmodule

// File: tb/tb_esi_cycle_count_responder.sv
// Self-checking bench for esi_cycle_count_responder with a queue-based
// reference model of the counter, lap register and pending responses.
module tb_esi_cycle_count_responder;

    localparam logic [63:0] FREQ = 64'd100_000_000;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  op;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_data;
    logic [1:0]  resp_op;
    logic        resp_err;
    logic [63:0] cycle_count;

    int checks = 0;
    int errors = 0;

    logic [63:0] mcount = '0;
    logic [63:0] mlap = '0;
    int          ntransfers = 0;
    exp_t        expq[$];

    esi_cycle_count_responder #(.CORE_CLOCK_FREQUENCY_HZ(FREQ)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data(resp_data),
        .resp_op(resp_op),
        .resp_err(resp_err),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Reference model: counts edges since reset, and keeps the pending
    // responses as a queue computed from the opcode rules.
    always @(posedge clk or negedge rst) begin : model
        bit   had;
        exp_t e;
        if (!rst) begin
            mcount = '0;
            mlap   = '0;
            expq.delete();
        end else begin
            had = (expq.size() != 0);
            if (had && resp_ready) begin
                void'(expq.pop_front());
                ntransfers++;
            end
            if (req_valid && (!had || resp_ready)) begin
                e.op  = req_op;
                e.err = 1'b0;
                case (req_op)
                    2'd0: e.data = mcount;
                    2'd1: e.data = FREQ;
                    2'd2: begin
                        e.data = mcount - mlap;
                        mlap   = mcount;
                    end
                    default: begin
                        e.data = 64'hFFFF_FFFF_FFFF_FFFF;
                        e.err  = 1'b1;
                    end
                endcase
                expq.push_back(e);
            end
            mcount = mcount + 64'd1;
        end
    end

    // Drive one cycle of inputs just after the rising edge.
    task automatic step(input logic v, input logic [1:0] op, input logic rr);
        @(posedge clk);
        #1;
        req_valid  = v;
        req_op     = op;
        resp_ready = rr;
    endtask

    // Pulse reset for one cycle, then release with inputs idle.
    task automatic reset_release();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (cycle_count !== 64'd0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: count=%0d valid=%b ready=%b want 0/0/0", cycle_count, resp_valid, req_ready);
        end
        checks++;
        if (resp_data !== 64'd0 || resp_op !== 2'd0 || resp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_payload: data=%h op=%0d err=%b want 0/0/0", resp_data, resp_op, resp_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 2'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (cycle_count !== 64'd10 || cycle_count !== mcount) begin
            errors++;
            $display("[TB] FAIL count_after_10: got %0d want 10", cycle_count);
        end
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL idle_hs: valid=%b ready=%b want 0/1", resp_valid, req_ready);
        end
    endtask

    task automatic test_read_count();
        reset_release();
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b0);
        step(1'b1, 2'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (cycle_count !== 64'd5) begin
            errors++;
            $display("[TB] FAIL count_at_accept: got %0d want 5", cycle_count);
        end
        step(1'b0, 2'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 64'd5 || resp_op !== 2'd0 || resp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_count: valid=%b data=%0d op=%0d err=%b want 1/5/0/0", resp_valid, resp_data, resp_op, resp_err);
        end
        step(1'b0, 2'd0, 1'b1);
    endtask

    task automatic test_freq_stall();
        int t0;
        step(1'b1, 2'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'd0, 1'b0);
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== FREQ || resp_op !== 2'd1 || req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL freq_hold[%0d]: valid=%b data=%0d op=%0d ready=%b want 1/%0d/1/0", i, resp_valid, resp_data, resp_op, req_ready, FREQ);
            end
        end
        t0 = ntransfers;
        step(1'b0, 2'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL freq_release_ready: got %b want 1", req_ready);
        end
        step(1'b0, 2'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || ntransfers - t0 !== 1) begin
            errors++;
            $display("[TB] FAIL freq_one_xfer: valid=%b xfers=%0d want 0/1", resp_valid, ntransfers - t0);
        end
    endtask

    task automatic test_lap();
        reset_release();
        for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 1'b1);
        step(1'b1, 2'd2, 1'b1);
        step(1'b0, 2'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 64'd7 || resp_op !== 2'd2) begin
            errors++;
            $display("[TB] FAIL lap_first: valid=%b data=%0d op=%0d want 1/7/2", resp_valid, resp_data, resp_op);
        end
        for (int i = 0; i < 11; i++) step(1'b0, 2'd0, 1'b1);
        step(1'b1, 2'd2, 1'b1);
        step(1'b0, 2'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 64'd13) begin
            errors++;
            $display("[TB] FAIL lap_second: valid=%b data=%0d want 1/13", resp_valid, resp_data);
        end
        @(posedge clk);
        #1;
        force dut.count_q = 64'hFFFF_FFFF_FFFF_FFFC;
        mcount = 64'hFFFF_FFFF_FFFF_FFFC;
        req_valid = 1'b1;
        req_op = 2'd2;
        resp_ready = 1'b1;
        #1;
        release dut.count_q;
        step(1'b0, 2'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (resp_data !== 64'hFFFF_FFFF_FFFF_FFFC - 64'd20 || resp_data !== expq[0].data) begin
            errors++;
            $display("[TB] FAIL lap_to_high: got %h want %h", resp_data, 64'hFFFF_FFFF_FFFF_FFFC - 64'd20);
        end
        step(1'b1, 2'd2, 1'b1);
        @(negedge clk);
        checks++;
        if (cycle_count !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            errors++;
            $display("[TB] FAIL count_near_wrap: got %h want fffffffffffffffe", cycle_count);
        end
        step(1'b0, 2'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 64'd2) begin
            errors++;
            $display("[TB] FAIL lap_near_wrap: valid=%b data=%0d want 1/2", resp_valid, resp_data);
        end
        step(1'b0, 2'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (cycle_count !== 64'd0) begin
            errors++;
            $display("[TB] FAIL count_wrap: got %h want 0", cycle_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops [3] = '{2'd0, 2'd1, 2'd3};
        for (int i = 0; i < 4; i++) begin
            step(i < 3, (i < 3) ? ops[i] : 2'd0, 1'b1);
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_op !== ops[i-1] || expq.size() == 0 || resp_data !== expq[0].data) begin
                    errors++;
                    $display("[TB] FAIL b2b[%0d]: valid=%b op=%0d data=%h want 1/%0d/model", i, resp_valid, resp_op, resp_data, ops[i-1]);
                end
            end
            if (i == 3) begin
                checks++;
                if (resp_data !== 64'hFFFF_FFFF_FFFF_FFFF || resp_err !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_reserved: data=%h err=%b want all-ones/1", resp_data, resp_err);
                end
            end
        end
        step(1'b0, 2'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_drain: valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_random();
        int nacc;
        int nout;
        nacc = 0;
        nout = ntransfers;
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
            @(negedge clk);
            checks++;
            if (resp_valid !== (expq.size() != 0) || req_ready !== (expq.size() == 0 || resp_ready)
                || cycle_count !== mcount) begin
                errors++;
                $display("[TB] FAIL rand_hs[%0d]: valid=%b ready=%b count=%0d want %b/%b/%0d", i, resp_valid, req_ready, cycle_count, expq.size() != 0, expq.size() == 0 || resp_ready, mcount);
            end
            if (expq.size() != 0) begin
                checks++;
                if (resp_data !== expq[0].data || resp_op !== expq[0].op || resp_err !== expq[0].err) begin
                    errors++;
                    $display("[TB] FAIL rand_resp[%0d]: data=%h op=%0d err=%b want %h/%0d/%b", i, resp_data, resp_op, resp_err, expq[0].data, expq[0].op, expq[0].err);
                end
            end
        end
        step(1'b0, 2'd0, 1'b1);
        step(1'b0, 2'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL rand_drain: valid=%b pending=%0d want 0/0", resp_valid, expq.size());
        end
    endtask

    task automatic test_reset_midcycle();
        step(1'b1, 2'd0, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_pending: valid=%b want 1", resp_valid);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || cycle_count !== 64'd0 || req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: valid=%b count=%0d ready=%b want 0/0/0", resp_valid, cycle_count, req_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, 2'd0, 1'b1);
        step(1'b0, 2'd0, 1'b1);
        step(1'b1, 2'd2, 1'b1);
        step(1'b0, 2'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 64'd3 || resp_op !== 2'd2) begin
            errors++;
            $display("[TB] FAIL mid_lap: valid=%b data=%0d op=%0d want 1/3/2", resp_valid, resp_data, resp_op);
        end
        step(1'b0, 2'd0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_read_count();
        test_freq_stall();
        test_lap();
        test_back_to_back();
        test_random();
        test_reset_midcycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
